// File: rtl/rx_iq_buffer.sv
// rx_iq_buffer: FIFO that holds decimated receive IQ samples until the MCU
// pops them one entry at a time.
// Each entry holds one rx_valid strobe's worth of samples, written as a unit.
// Without RX_IQ_BUFFER_RX2_EN an entry holds RX1 I/Q only (48 bits). The RX2
// outputs are then tied to zero.
// With RX_IQ_BUFFER_RX2_EN an entry holds RX1 and RX2 I/Q (96 bits).
//
// Transfer semantics:
//   write - rx_valid is a one-cycle strobe with no back-pressure. It is
//           accepted when the buffer is not full, or when a real pop happens
//           in the same cycle. Otherwise it is dropped and iq_overrun is set.
//   pop   - a 0->1 transition of IQ_RX_READ_CLK while IQ_RX_READ_REQ is high.
//           On a non-empty buffer, the head entry is registered onto the
//           sample outputs at that same edge (1-cycle latency) and the entry
//           is retired. On an empty buffer, iq_underrun is set and the
//           outputs hold their value. A write in the same cycle never falls
//           through.
module rx_iq_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [23:0]           RX1_I_in,
  input  logic [23:0]           RX1_Q_in,
  input  logic [23:0]           RX2_I_in,
  input  logic [23:0]           RX2_Q_in,
  input  logic                  rx_valid,
  input  logic                  IQ_RX_READ_REQ,
  input  logic                  IQ_RX_READ_CLK,
  input  logic                  ovr_clear,
  output logic [23:0]           RX1_I,
  output logic [23:0]           RX1_Q,
  output logic [23:0]           RX2_I,
  output logic [23:0]           RX2_Q,
  output logic                  in_empty,
  output logic                  iq_overrun,
  output logic                  iq_underrun,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

`ifdef RX_IQ_BUFFER_RX2_EN
  localparam int ENTRY_W = 96;
`else
  localparam int ENTRY_W = 48;
`endif

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  empty_q, empty_d;
  logic                  ovr_q, ovr_d;
  logic                  unr_q, unr_d;
  logic                  rd_clk_q;

  logic                  pop_evt;
  logic                  is_empty;
  logic                  is_full;
  logic                  do_pop;
  logic                  do_wr;
  logic                  set_ovr;
  logic                  set_unr;

  logic [23:0]           rx1_i_q, rx1_q_q;

`ifdef RX_IQ_BUFFER_RX2_EN
  logic [23:0]           rx2_i_q, rx2_q_q;
  assign wr_entry = {RX2_Q_in, RX2_I_in, RX1_Q_in, RX1_I_in};
`else
  // The RX2 inputs are ignored in this build.
  logic                  unused_rx2;
  assign unused_rx2 = ^{RX2_I_in, RX2_Q_in};
  assign wr_entry   = {RX1_Q_in, RX1_I_in};
`endif

  assign rd_entry = mem_q[rd_ptr_q];

  // Decode the pop edge and the write/pop/flag events. Full and empty come
  // from the fill count, because the pointers are equal both when full and
  // when empty.
  always_comb begin
    pop_evt  = IQ_RX_READ_REQ & IQ_RX_READ_CLK & ~rd_clk_q;
    is_empty = (fill_q == '0);
    is_full  = (fill_q == FULL_LVL);
    do_pop   = pop_evt & ~is_empty;
    do_wr    = rx_valid & (~is_full | do_pop);
    set_ovr  = rx_valid & is_full & ~do_pop;
    set_unr  = pop_evt & is_empty;
  end

  // Compute the next pointers, fill count and sticky flags. A set event in
  // the same cycle as ovr_clear keeps its flag set.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_wr)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_pop})
      2'b10:   fill_d = fill_q + LVL_ONE;
      2'b01:   fill_d = fill_q - LVL_ONE;
      default: fill_d = fill_q;
    endcase
    empty_d = (fill_d == '0);
    ovr_d   = set_ovr | (ovr_q & ~ovr_clear);
    unr_d   = set_unr | (unr_q & ~ovr_clear);
  end

  // Register pointers, fill count, flags and the read-strobe history.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      empty_q  <= 1'b1;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
      rd_clk_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      empty_q  <= empty_d;
      ovr_q    <= ovr_d;
      unr_q    <= unr_d;
      rd_clk_q <= IQ_RX_READ_CLK;
    end
  end

  // Sample storage. This memory is not reset; the pointers decide which
  // entries are live.
  always_ff @(posedge clk_in) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Load the head entry onto the outputs on a real pop. Otherwise the
  // outputs hold their value.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx1_i_q <= '0;
      rx1_q_q <= '0;
`ifdef RX_IQ_BUFFER_RX2_EN
      rx2_i_q <= '0;
      rx2_q_q <= '0;
`endif
    end else if (do_pop) begin
      rx1_i_q <= rd_entry[23:0];
      rx1_q_q <= rd_entry[47:24];
`ifdef RX_IQ_BUFFER_RX2_EN
      rx2_i_q <= rd_entry[71:48];
      rx2_q_q <= rd_entry[95:72];
`endif
    end
  end

  assign RX1_I       = rx1_i_q;
  assign RX1_Q       = rx1_q_q;
`ifdef RX_IQ_BUFFER_RX2_EN
  assign RX2_I       = rx2_i_q;
  assign RX2_Q       = rx2_q_q;
`else
  assign RX2_I       = '0;
  assign RX2_Q       = '0;
`endif
  assign in_empty    = empty_q;
  assign iq_overrun  = ovr_q;
  assign iq_underrun = unr_q;
  assign fill_level  = fill_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// tb_rx_iq_buffer: checks rx_iq_buffer against a queue-based reference model
// on every cycle, with directed scenarios pinned by literal expectations
// followed by randomized traffic. Also valid with RX_IQ_BUFFER_RX2_EN defined.
module tb_rx_iq_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [23:0] r1i, r1q, r2i, r2q;
  logic        rx_valid, req, rclk, clr;
  logic [23:0] o1i, o1q, o2i, o2q;
  logic        o_empty, o_ovr, o_unr;
  logic [DL:0] o_fill;

  rx_iq_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk_in(clk), .reset(rst),
    .RX1_I_in(r1i), .RX1_Q_in(r1q), .RX2_I_in(r2i), .RX2_Q_in(r2q),
    .rx_valid(rx_valid), .IQ_RX_READ_REQ(req), .IQ_RX_READ_CLK(rclk),
    .ovr_clear(clr),
    .RX1_I(o1i), .RX1_Q(o1q), .RX2_I(o2i), .RX2_Q(o2q),
    .in_empty(o_empty), .iq_overrun(o_ovr), .iq_underrun(o_unr),
    .fill_level(o_fill)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [95:0] m_q[$];
  logic [95:0] m_out;
  bit          m_ovr, m_unr, m_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_out  = '0;
      m_ovr  = 1'b0;
      m_unr  = 1'b0;
      m_prev = 1'b0;
    end else begin
      bit pop, was_empty, was_full, set_o, set_u;
      pop       = req && rclk && !m_prev;
      m_prev    = rclk;
      was_empty = (m_q.size() == 0);
      was_full  = (m_q.size() == DEPTH);
      set_o     = 1'b0;
      set_u     = 1'b0;
      if (pop) begin
        if (was_empty) set_u = 1'b1;
        else m_out = m_q.pop_front();
      end
      if (rx_valid) begin
        if (!was_full || (pop && !was_empty)) m_q.push_back({r2q, r2i, r1q, r1i});
        else set_o = 1'b1;
      end
      if (set_o) m_ovr = 1'b1; else if (clr) m_ovr = 1'b0;
      if (set_u) m_unr = 1'b1; else if (clr) m_unr = 1'b0;
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (check_en) begin
      logic [23:0] e2i, e2q;
`ifdef RX_IQ_BUFFER_RX2_EN
      e2i = m_out[71:48];
      e2q = m_out[95:72];
`else
      e2i = '0;
      e2q = '0;
`endif
      chk("fill_level",  32'(o_fill),  32'(m_q.size()));
      chk("in_empty",    32'(o_empty), 32'(m_q.size() == 0));
      chk("iq_overrun",  32'(o_ovr),   32'(m_ovr));
      chk("iq_underrun", 32'(o_unr),   32'(m_unr));
      chk("RX1_I",       32'(o1i),     32'(m_out[23:0]));
      chk("RX1_Q",       32'(o1q),     32'(m_out[47:24]));
      chk("RX2_I",       32'(o2i),     32'(e2i));
      chk("RX2_Q",       32'(o2q),     32'(e2q));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [23:0] a, input logic [23:0] b,
                      input logic [23:0] c, input logic [23:0] d,
                      input bit rq, input bit rc, input bit cl);
    rx_valid = v; r1i = a; r1q = b; r2i = c; r2q = d;
    req = rq; rclk = rc; clr = cl;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 24'h0, 24'h0, 24'h0, 24'h0, 0, 0, 0);
  endtask

  task automatic wr(input logic [23:0] a);
    step(1, a, ~a, 24'h0, 24'h0, 0, 0, 0);
  endtask

  task automatic pop_chk(input string name, input logic [23:0] exp);
    step(0, 24'h0, 24'h0, 24'h0, 24'h0, 1, 1, 0);
    chk(name, 32'(o1i), 32'(exp));
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    rx_valid = 0; req = 0; rclk = 0; clr = 0;
    r1i = 0; r1q = 0; r2i = 0; r2q = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;

    // reset state
    chk("rst_fill",  32'(o_fill),  32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_ovr",   32'(o_ovr),   32'd0);
    chk("rst_rx1i",  32'(o1i),     32'd0);

    // three writes, three pops in order
    for (int i = 1; i <= 3; i++) wr(24'(i));
    chk("three_fill", 32'(o_fill), 32'd3);
    for (int i = 1; i <= 3; i++) pop_chk("order_pop", 24'(i));
    chk("three_empty", 32'(o_empty), 32'd1);

    // pop while empty, then clear
    pop_chk("underrun_hold", 24'd3);
    chk("underrun_set", 32'(o_unr), 32'd1);
    step(0, 24'h0, 24'h0, 24'h0, 24'h0, 0, 0, 1);
    chk("clear_unr", 32'(o_unr), 32'd0);
    chk("clear_ovr", 32'(o_ovr), 32'd0);

    // write + pop while empty: no fall-through
    step(1, 24'h77, 24'h0, 24'h0, 24'h0, 1, 1, 0);
    chk("wp_empty_fill", 32'(o_fill), 32'd1);
    chk("wp_empty_unr",  32'(o_unr),  32'd1);
    chk("wp_empty_out",  32'(o1i),    32'd3);
    idle();
    pop_chk("wp_empty_pop", 24'h77);

    // overrun: 17 writes into 16 entries
    do_reset();
    for (int i = 0; i < 17; i++) wr(24'(8'h10 + i));
    chk("ovr_fill", 32'(o_fill), 32'd16);
    chk("ovr_set",  32'(o_ovr),  32'd1);
    for (int i = 0; i < 16; i++) pop_chk("ovr_readback", 24'(8'h10 + i));
    chk("ovr_drained", 32'(o_fill), 32'd0);
    pop_chk("ovr_17th_absent", 24'h1F);

    // full with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 16; i++) wr(24'(12'h100 + i));
    step(1, 24'h200, 24'h0, 24'h0, 24'h0, 1, 1, 0);
    chk("full_wp_fill", 32'(o_fill), 32'd16);
    chk("full_wp_ovr",  32'(o_ovr),  32'd0);
    chk("full_wp_out",  32'(o1i),    32'h100);
    idle();
    for (int i = 1; i < 16; i++) pop_chk("full_wp_read", 24'(12'h100 + i));
    pop_chk("full_wp_last", 24'h200);

    // read strobe held high: one pop with request, none without
    do_reset();
    wr(24'h55); wr(24'h66);
    for (int i = 0; i < 5; i++) step(0, 24'h0, 24'h0, 24'h0, 24'h0, 1, 1, 0);
    chk("hold_one_pop", 32'(o_fill), 32'd1);
    chk("hold_out",     32'(o1i),    32'h55);
    idle();
    for (int i = 0; i < 5; i++) step(0, 24'h0, 24'h0, 24'h0, 24'h0, 0, 1, 0);
    chk("noreq_fill", 32'(o_fill), 32'd1);
    idle();
    pop_chk("hold_next", 24'h66);

    // RX2 path
    do_reset();
    step(1, 24'hA, 24'hB, 24'h123456, 24'h654321, 0, 0, 0);
    pop_chk("rx2_rx1i", 24'hA);
`ifdef RX_IQ_BUFFER_RX2_EN
    chk("rx2_i", 32'(o2i), 32'h123456);
`else
    chk("rx2_i", 32'(o2i), 32'h0);
`endif

    // reset mid-transfer discards entries
    wr(24'h31); wr(24'h32); wr(24'h33);
    do_reset();
    chk("midrst_fill",  32'(o_fill),  32'd0);
    chk("midrst_empty", 32'(o_empty), 32'd1);
    wr(24'h99);
    pop_chk("midrst_new", 24'h99);

    // pop edge in the first cycle after reset release
    req = 1; rclk = 1; rx_valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_cycle_pop", 32'(o_unr), 32'd1);
    idle();

    // randomized traffic in write-heavy and read-heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 85 : 25;
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(0, 99) < wp,
             24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom),
             $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 29) == 0);
      end
    end
    idle();
    @(negedge clk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
